// File: rtl/iq_phase_discriminator.sv
// Conjugate-product discriminator: emits x[n]*conj(x[n-1]) >>> SHIFT, 4-edge latency, fully pipelined.
// Define IQ_DISC_SAT_EN to saturate the scaled result (adds sat_flag) instead of wrapping.
module iq_phase_discriminator #(
    parameter int SHIFT  = 31,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [DATA_W-1:0] sig_demod_real,
    input  logic [DATA_W-1:0] sig_demod_imag,
    input  logic              sample_valid,
    input  logic              flush,
    output logic [DATA_W-1:0] disc_real,
    output logic [DATA_W-1:0] disc_imag,
    output logic              disc_valid,
    output logic              primed
`ifdef IQ_DISC_SAT_EN
    ,
    output logic              sat_flag
`endif
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = 2 * DATA_W + 1;

    typedef enum logic {
        PRIME,
        RUN
    } state_t;

    state_t state;
    state_t next_state;
    logic   issue;

    logic signed [DATA_W-1:0] cur_i;
    logic signed [DATA_W-1:0] cur_q;
    logic signed [DATA_W-1:0] prv_i;
    logic signed [DATA_W-1:0] prv_q;

    logic s1_v;
    logic s2_v;
    logic s3_v;

    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_qq;
    logic signed [PW-1:0] p_qi;
    logic signed [PW-1:0] p_iq;

    logic signed [SW-1:0] re_sum;
    logic signed [SW-1:0] im_sum;

    logic [DATA_W-1:0] re_out;
    logic [DATA_W-1:0] im_out;

    function automatic logic signed [PW-1:0] smul(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        ae = {{DATA_W{a[DATA_W-1]}}, a};
        be = {{DATA_W{b[DATA_W-1]}}, b};
        return ae * be;
    endfunction

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= PRIME;
        end else begin
            state <= next_state;
        end
    end

    // Flush wins over a coincident sample, which is simply dropped.
    always_comb begin
        next_state = state;
        issue      = 1'b0;
        if (flush) begin
            next_state = PRIME;
        end else if (sample_valid) begin
            case (state)
                PRIME: next_state = RUN;
                RUN:   issue      = 1'b1;
                default: next_state = PRIME;
            endcase
        end
    end

    assign primed = (state == RUN);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cur_i <= '0;
            cur_q <= '0;
            prv_i <= '0;
            prv_q <= '0;
        end else if (flush) begin
            cur_i <= '0;
            cur_q <= '0;
            prv_i <= '0;
            prv_q <= '0;
        end else if (sample_valid) begin
            cur_i <= sig_demod_real;
            cur_q <= sig_demod_imag;
            if (state == RUN) begin
                prv_i <= cur_i;
                prv_q <= cur_q;
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            s1_v <= issue;
            s2_v <= s1_v && !flush;
            s3_v <= s2_v && !flush;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            p_ii <= '0;
            p_qq <= '0;
            p_qi <= '0;
            p_iq <= '0;
        end else if (s1_v) begin
            p_ii <= smul(cur_i, prv_i);
            p_qq <= smul(cur_q, prv_q);
            p_qi <= smul(cur_q, prv_i);
            p_iq <= smul(cur_i, prv_q);
        end
    end

    // One guard bit keeps the sum and difference of two full-scale products exact.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            re_sum <= '0;
            im_sum <= '0;
        end else if (s2_v) begin
            re_sum <= {p_ii[PW-1], p_ii} + {p_qq[PW-1], p_qq};
            im_sum <= {p_qi[PW-1], p_qi} - {p_iq[PW-1], p_iq};
        end
    end

`ifdef IQ_DISC_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = {{(DATA_W + 1){1'b0}}, 1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};
    localparam logic [DATA_W-1:0]    OUT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
    localparam logic [DATA_W-1:0]    OUT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

    logic signed [SW-1:0] re_sh;
    logic signed [SW-1:0] im_sh;
    logic                 re_clip;
    logic                 im_clip;

    always_comb begin
        re_sh   = re_sum >>> SHIFT;
        im_sh   = im_sum >>> SHIFT;
        re_clip = (re_sh > SAT_MAX) || (re_sh < SAT_MIN);
        im_clip = (im_sh > SAT_MAX) || (im_sh < SAT_MIN);
        re_out  = re_sh[DATA_W-1:0];
        im_out  = im_sh[DATA_W-1:0];
        if (re_clip) begin
            re_out = re_sh[SW-1] ? OUT_MIN : OUT_MAX;
        end
        if (im_clip) begin
            im_out = im_sh[SW-1] ? OUT_MIN : OUT_MAX;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= s3_v && !flush && (re_clip || im_clip);
        end
    end
`else
    always_comb begin
        re_out = DATA_W'(re_sum >>> SHIFT);
        im_out = DATA_W'(im_sum >>> SHIFT);
    end
`endif

    // Outputs only move with a result, so they keep the last value between strobes.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            disc_real  <= '0;
            disc_imag  <= '0;
            disc_valid <= 1'b0;
        end else begin
            disc_valid <= s3_v && !flush;
            if (s3_v && !flush) begin
                disc_real <= re_out;
                disc_imag <= im_out;
            end
        end
    end

endmodule

// File: tb/tb_iq_phase_discriminator.sv
// Table-driven, scoreboarded bench for iq_phase_discriminator (wrap or IQ_DISC_SAT_EN build).
module tb_iq_phase_discriminator;

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        int          gap;
        logic        has_out;
        logic [31:0] re;
        logic [31:0] im;
    } vec_t;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        int          cyc;
    } exp_t;

    localparam int NV = 8;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] sig_demod_real = '0;
    logic [31:0] sig_demod_imag = '0;
    logic        sample_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] disc_real;
    logic [31:0] disc_imag;
    logic        disc_valid;
    logic        primed;

    logic [31:0] s0_real = '0;
    logic [31:0] s0_imag = '0;
    logic        s0_valid = 1'b0;
    logic        s0_flush = 1'b0;
    logic [31:0] d0_real;
    logic [31:0] d0_imag;
    logic        d0_valid;
    logic        d0_primed;

`ifdef IQ_DISC_SAT_EN
    logic sat_flag;
    logic sat_flag0;
`endif

    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;
    int   valid_count = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[NV];

    iq_phase_discriminator #(.SHIFT(31)) dut (
        .clock(clock),
        .rst(rst),
        .sig_demod_real(sig_demod_real),
        .sig_demod_imag(sig_demod_imag),
        .sample_valid(sample_valid),
        .flush(flush),
        .disc_real(disc_real),
        .disc_imag(disc_imag),
        .disc_valid(disc_valid),
        .primed(primed)
`ifdef IQ_DISC_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    iq_phase_discriminator #(.SHIFT(0)) dut0 (
        .clock(clock),
        .rst(rst),
        .sig_demod_real(s0_real),
        .sig_demod_imag(s0_imag),
        .sample_valid(s0_valid),
        .flush(s0_flush),
        .disc_real(d0_real),
        .disc_imag(d0_imag),
        .disc_valid(d0_valid),
        .primed(d0_primed)
`ifdef IQ_DISC_SAT_EN
        ,
        .sat_flag(sat_flag0)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_compared++;
        if (act !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Every result strobe must match the oldest outstanding expectation, on its exact cycle.
    always @(negedge clock) begin
        if (disc_valid) begin
            valid_count++;
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_valid: got disc_valid=1, expected 0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check_output("disc_real", disc_real, mon_e.re);
                check_output("disc_imag", disc_imag, mon_e.im);
                check_output("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
`ifdef IQ_DISC_SAT_EN
                check_output("sat_flag", {31'b0, sat_flag}, 32'h0);
`endif
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] i, input logic [31:0] q, input logic has_out,
                                  input logic [31:0] re, input logic [31:0] im);
        exp_t e;
        sig_demod_real = i;
        sig_demod_imag = q;
        sample_valid   = 1'b1;
        if (has_out) begin
            e.re  = re;
            e.im  = im;
            e.cyc = cyc + 4;
            sb.push_back(e);
        end
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clock);
        check_output("queue_drained", 32'(sb.size()), 32'h0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          vc0;
        logic        got;
        logic [31:0] exp_sat_re;

        vecs[0] = '{32'h10000000, 32'h00000000, 2, 1'b0, 32'h00000000, 32'h00000000};
        vecs[1] = '{32'h10000000, 32'h00000000, 0, 1'b1, 32'h02000000, 32'h00000000};
        vecs[2] = '{32'h00000000, 32'h10000000, 0, 1'b1, 32'h00000000, 32'h02000000};
        vecs[3] = '{32'hF0000000, 32'h00000000, 0, 1'b1, 32'h00000000, 32'h02000000};
        vecs[4] = '{32'h10000000, 32'h00000000, 1, 1'b1, 32'hFE000000, 32'h00000000};
        vecs[5] = '{32'h00000000, 32'hF0000000, 0, 1'b1, 32'h00000000, 32'hFE000000};
        vecs[6] = '{32'h08000000, 32'h08000000, 0, 1'b1, 32'hFF000000, 32'h01000000};
        vecs[7] = '{32'h40000000, 32'h00000000, 3, 1'b1, 32'h04000000, 32'hFC000000};

        repeat (3) @(negedge clock);
        check_output("reset_disc_real", disc_real, 32'h0);
        check_output("reset_disc_imag", disc_imag, 32'h0);
        check_output("reset_disc_valid", {31'b0, disc_valid}, 32'h0);
        check_output("reset_primed", {31'b0, primed}, 32'h0);
        rst = 1'b1;
        @(negedge clock);

        // Full-scale pair at SHIFT=0: wraps to 2, or clips to max when saturation is built in.
`ifdef IQ_DISC_SAT_EN
        exp_sat_re = 32'h7FFFFFFF;
`else
        exp_sat_re = 32'h00000002;
`endif
        s0_real  = 32'h7FFFFFFF;
        s0_imag  = 32'h7FFFFFFF;
        s0_valid = 1'b1;
        repeat (2) @(negedge clock);
        s0_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clock);
            got = d0_valid;
        end
        check_output("shift0_valid_seen", {31'b0, got}, 32'h1);
        check_output("shift0_disc_real", d0_real, exp_sat_re);
        check_output("shift0_disc_imag", d0_imag, 32'h0);
`ifdef IQ_DISC_SAT_EN
        check_output("shift0_sat_flag", {31'b0, sat_flag0}, 32'h1);
`endif
        @(negedge clock);
        check_output("shift0_valid_pulse", {31'b0, d0_valid}, 32'h0);

        for (int n = 0; n < NV; n++) begin
            apply_stimulus(vecs[n].i, vecs[n].q, vecs[n].has_out, vecs[n].re, vecs[n].im);
            if (n == 0) check_output("primed_after_first", {31'b0, primed}, 32'h1);
            repeat (vecs[n].gap) @(negedge clock);
        end
        wait_drain();

        // Two products in flight when flush lands: neither may appear, outputs hold.
        repeat (4) @(negedge clock);
        #1 vc0 = valid_count;
        apply_stimulus(32'h12345678, 32'h0ABCDEF0, 1'b0, 32'h0, 32'h0);
        apply_stimulus(32'h01000000, 32'h7FFFFFFF, 1'b0, 32'h0, 32'h0);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check_output("flush_primed", {31'b0, primed}, 32'h0);
        repeat (8) @(negedge clock);
        #1;
        check_output("flush_no_valid", 32'(valid_count - vc0), 32'h0);
        check_output("flush_hold_real", disc_real, 32'h04000000);
        check_output("flush_hold_imag", disc_imag, 32'hFC000000);

        @(negedge clock);
        sig_demod_real = 32'h30000000;
        sig_demod_imag = 32'h00000000;
        sample_valid   = 1'b1;
        flush          = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        flush        = 1'b0;
        check_output("flush_prio_primed", {31'b0, primed}, 32'h0);
        apply_stimulus(32'h10000000, 32'h00000000, 1'b0, 32'h0, 32'h0);
        apply_stimulus(32'h00000000, 32'h10000000, 1'b1, 32'h00000000, 32'h02000000);
        wait_drain();

        // Reset lands with two results still in the pipe.
        repeat (2) @(negedge clock);
        apply_stimulus(32'h22222222, 32'h11111111, 1'b0, 32'h0, 32'h0);
        apply_stimulus(32'h33333333, 32'h44444444, 1'b0, 32'h0, 32'h0);
        #3 rst = 1'b0;
        #1;
        check_output("midrst_disc_real", disc_real, 32'h0);
        check_output("midrst_disc_imag", disc_imag, 32'h0);
        check_output("midrst_disc_valid", {31'b0, disc_valid}, 32'h0);
        check_output("midrst_primed", {31'b0, primed}, 32'h0);
        repeat (2) @(negedge clock);
        rst = 1'b1;
        #1 vc0 = valid_count;
        repeat (8) @(negedge clock);
        #1;
        check_output("postrst_no_valid", 32'(valid_count - vc0), 32'h0);
        check_output("postrst_disc_real", disc_real, 32'h0);
        check_output("postrst_primed", {31'b0, primed}, 32'h0);
        @(negedge clock);
        apply_stimulus(32'h20000000, 32'h10000000, 1'b0, 32'h0, 32'h0);
        check_output("postrst_primed_first", {31'b0, primed}, 32'h1);
        apply_stimulus(32'h10000000, 32'h20000000, 1'b1, 32'h08000000, 32'h06000000);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
